// File: rtl/arb3_rr.sv
// Three-source round-robin packet arbiter: locks the winning source until its
// packet ends or the burst limit is hit, and drives the registered mux3 select.
module arb3_rr #(
   parameter int unsigned MAXBURST = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic [2:0] last,
   output logic [2:0] ack,
   output logic       o_valid,
   input  logic       o_ready,
   output logic [1:0] s,
   output logic       busy,
   output logic       dbg_lock,
   output logic [1:0] dbg_prev,
   output logic [3:0] dbg_cnt
);

   // Handshake: a beat transfers on any cycle where the locked source's req
   // (presented as o_valid) and the consumer's o_ready are both high; ack of
   // the locked source mirrors o_ready, all other acks stay low.

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   localparam logic [3:0] MB = 4'(MAXBURST);

   state_t     state, state_nxt;
   logic [1:0] prev, prev_nxt;
   logic [1:0] s_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       busy_nxt;

   logic [1:0] cand1, cand2, cand3, winner;
   logic       req_s, last_s, beat, burst_hit, rel;
   logic [3:0] cnt_inc;

   function automatic logic [1:0] next_src(input logic [1:0] x);
      return (x >= 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   function automatic logic bit_of(input logic [2:0] v, input logic [1:0] i);
      logic b;
      case (i)
         2'd0:    b = v[0];
         2'd1:    b = v[1];
         2'd2:    b = v[2];
         default: b = 1'b0;
      endcase
      return b;
   endfunction

   function automatic logic [2:0] onehot(input logic [1:0] i);
      logic [2:0] v;
      case (i)
         2'd0:    v = 3'b001;
         2'd1:    v = 3'b010;
         2'd2:    v = 3'b100;
         default: v = 3'b000;
      endcase
      return v;
   endfunction

   // Search order starts just after the last granted source.
   always_comb begin
      cand1 = next_src(prev);
      cand2 = next_src(cand1);
      cand3 = next_src(cand2);
      if (bit_of(req, cand1))
         winner = cand1;
      else if (bit_of(req, cand2))
         winner = cand2;
      else
         winner = cand3;
   end

   always_comb begin
      req_s     = bit_of(req, s);
      last_s    = bit_of(last, s);
      beat      = (state == LOCK) && req_s && o_ready;
      cnt_inc   = (cnt == 4'hF) ? cnt : cnt + 4'd1;
      burst_hit = (MB != 4'd0) && (cnt_inc == MB);
      rel       = beat && (last_s || burst_hit);
   end

   always_comb begin
      state_nxt = state;
      s_nxt     = s;
      prev_nxt  = prev;
      cnt_nxt   = cnt;
      busy_nxt  = busy;
      ack       = 3'b000;
      o_valid   = 1'b0;
      case (state)
         IDLE: begin
            if (req != 3'b000) begin
               state_nxt = LOCK;
               s_nxt     = winner;
               busy_nxt  = 1'b1;
               cnt_nxt   = 4'd0;
            end
         end
         LOCK: begin
            o_valid = req_s;
            ack     = onehot(s) & {3{o_ready}};
            if (beat)
               cnt_nxt = cnt_inc;
            if (rel) begin
               state_nxt = IDLE;
               prev_nxt  = s;
               busy_nxt  = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         s     <= 2'd0;
         prev  <= 2'd2;
         cnt   <= 4'd0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         s     <= s_nxt;
         prev  <= prev_nxt;
         cnt   <= cnt_nxt;
         busy  <= busy_nxt;
      end
   end

   assign dbg_lock = (state == LOCK);
   assign dbg_prev = prev;
   assign dbg_cnt  = cnt;

endmodule
